multicycle_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the CPU datapath. Walks each instruction through IF/ID/EXE/MEM/WB, drives the datapath enables and mux selects, and is a successor to the fixed-latency controller. New behaviour over that controller:
- variable-latency instruction/data memory via req/ready handshakes;
- configurable wait-state timeout with a sticky fault state;
- retired-instruction counter.

---
 rtl/multicycle_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle IF/ID/EXE/MEM/WB control sequencer with req/ready memory handshakes,
// wait-state timeout into a sticky FAULT state, and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int WAIT_W  = 5,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_wre,
  output logic             pc_wre,
  output logic [1:0]       pc_src,
  output logic             reg_wre,
  output logic [1:0]       reg_out,
  output logic             wr_reg_data,
  output logic             alu_m2reg,
  output logic             alu_src_b,
  output logic [1:0]       ext_sel,
  output logic [2:0]       alu_op,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WAIT_W-1:0]  wait_r;
  logic [WAIT_W-1:0]  wait_nxt_s;
  logic [CNT_W-1:0]   retired_r;
  logic               timeout_hit_s;

  logic       imem_req_s, ir_wre_s, pc_wre_s, reg_wre_s, dmem_req_s, dmem_we_s;
  logic [1:0] pc_src_s, reg_out_s, ext_sel_s;
  logic [2:0] alu_op_s;
  logic       wr_reg_data_s, alu_m2reg_s, alu_src_b_s;

  assign timeout_hit_s = TIMEOUT_EN && (wait_r == WAIT_LIMIT);

  // Next-state and datapath control decode
  always_comb begin
    state_nxt_s   = state_r;
    imem_req_s    = 1'b0;
    ir_wre_s      = 1'b0;
    pc_wre_s      = 1'b0;
    pc_src_s      = 2'd0;
    reg_wre_s     = 1'b0;
    reg_out_s     = 2'd0;
    wr_reg_data_s = 1'b0;
    alu_m2reg_s   = 1'b0;
    alu_src_b_s   = 1'b0;
    ext_sel_s     = 2'd0;
    alu_op_s      = 3'd0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    case (state_r)
      S_IF: begin
        imem_req_s = 1'b1;
        ir_wre_s   = imem_ready;
        if (imem_ready) begin
          state_nxt_s = S_ID;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_FAULT;
        end else begin
          state_nxt_s = S_IF;
        end
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            pc_wre_s    = 1'b1;
            pc_src_s    = 2'd3;
            state_nxt_s = S_IF;
          end
          OP_JAL: begin
            pc_wre_s      = 1'b1;
            pc_src_s      = 2'd3;
            reg_wre_s     = 1'b1;
            reg_out_s     = 2'd0;
            wr_reg_data_s = 1'b0;
            state_nxt_s   = S_IF;
          end
          OP_JR: begin
            pc_wre_s    = 1'b1;
            pc_src_s    = 2'd2;
            state_nxt_s = S_IF;
          end
          OP_HALT:                          state_nxt_s = S_HALT;
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_nxt_s = S_EXE;
          default:                          state_nxt_s = S_FAULT;
        endcase
      end
      S_EXE: begin
        case (opcode)
          OP_BEQ: begin
            alu_op_s    = 3'd1;
            pc_wre_s    = 1'b1;
            pc_src_s    = zero ? 2'd1 : 2'd0;
            state_nxt_s = S_IF;
          end
          OP_R: state_nxt_s = S_WB;
          OP_ADDI: begin
            alu_src_b_s = 1'b1;
            ext_sel_s   = 2'd1;
            state_nxt_s = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b_s = 1'b1;
            ext_sel_s   = 2'd1;
            state_nxt_s = S_MEM;
          end
          // Opcode changed after ID: treat as a hard fault rather than guess.
          default: state_nxt_s = S_FAULT;
        endcase
      end
      S_MEM: begin
        dmem_req_s  = 1'b1;
        dmem_we_s   = (opcode == OP_SW);
        alu_src_b_s = 1'b1;
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            pc_wre_s    = 1'b1;
            pc_src_s    = 2'd0;
            state_nxt_s = S_IF;
          end else begin
            state_nxt_s = S_WB;
          end
        end else if (timeout_hit_s) begin
          state_nxt_s = S_FAULT;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        reg_wre_s     = 1'b1;
        wr_reg_data_s = 1'b1;
        alu_m2reg_s   = (opcode == OP_LW);
        pc_wre_s      = 1'b1;
        pc_src_s      = 2'd0;
        reg_out_s     = (opcode == OP_R) ? 2'd2 : 2'd1;
        state_nxt_s   = S_IF;
      end
      S_HALT:  state_nxt_s = S_HALT;
      S_FAULT: state_nxt_s = S_FAULT;
      default: state_nxt_s = S_FAULT;
    endcase
  end

  // Wait counter advances only while a handshake is stalled in place
  always_comb begin
    if ((state_r == S_IF  && !imem_ready && state_nxt_s == S_IF) ||
        (state_r == S_MEM && !dmem_ready && state_nxt_s == S_MEM)) begin
      wait_nxt_s = wait_r + WAIT_W'(1'b1);
    end else begin
      wait_nxt_s = '0;
    end
  end

  // State, wait and retired registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IF;
      wait_r    <= '0;
      retired_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
      if (pc_wre_s) begin
        retired_r <= retired_r + CNT_W'(1'b1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Enables are forced low while reset is held so an aborted instruction has no side effects.
  assign imem_req    = imem_req_s & rst_n;
  assign ir_wre      = ir_wre_s   & rst_n;
  assign pc_wre      = pc_wre_s   & rst_n;
  assign reg_wre     = reg_wre_s  & rst_n;
  assign dmem_req    = dmem_req_s & rst_n;
  assign dmem_we     = dmem_we_s  & rst_n;
  assign pc_src      = pc_src_s;
  assign reg_out     = reg_out_s;
  assign wr_reg_data = wr_reg_data_s;
  assign alu_m2reg   = alu_m2reg_s;
  assign alu_src_b   = alu_src_b_s;
  assign ext_sel     = ext_sel_s;
  assign alu_op      = alu_op_s;
  assign state       = state_r;
  assign halted      = (state_r == S_HALT);
  assign fault       = (state_r == S_FAULT);
  assign retired     = retired_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Table-driven bench for multicycle_sequencer (TIMEOUT=4, 4-bit retired counter)
// plus hand-written sequences for halt, illegal opcode, timeouts and async reset.
module tb_multicycle_sequencer;

  localparam int CNT_W = 4;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] ADDI = 6'b000001;
  localparam logic [5:0] LW   = 6'b100111;
  localparam logic [5:0] SW   = 6'b100110;
  localparam logic [5:0] BEQ  = 6'b110000;
  localparam logic [5:0] J    = 6'b111000;
  localparam logic [5:0] JAL  = 6'b111010;
  localparam logic [5:0] JR   = 6'b111001;
  localparam logic [5:0] HALT = 6'b111111;
  localparam logic [5:0] ILL  = 6'b010101;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode;
  logic zero, imem_ready, dmem_ready;
  logic imem_req, ir_wre, pc_wre, reg_wre, wr_reg_data, alu_m2reg, alu_src_b;
  logic dmem_req, dmem_we, halted, fault;
  logic [1:0] pc_src, reg_out, ext_sel;
  logic [2:0] alu_op, state;
  logic [CNT_W-1:0] retired;

  multicycle_sequencer #(.TIMEOUT(4), .WAIT_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_wre(ir_wre), .pc_wre(pc_wre), .pc_src(pc_src),
    .reg_wre(reg_wre), .reg_out(reg_out), .wr_reg_data(wr_reg_data),
    .alu_m2reg(alu_m2reg), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
    .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .state(state), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_wre;
    logic       pc_wre;
    logic [1:0] pc_src;
    logic       reg_wre;
    logic [1:0] reg_out;
    logic       wr_reg_data;
    logic       alu_m2reg;
    logic       alu_src_b;
    logic [1:0] ext_sel;
    logic [2:0] alu_op;
    logic       dmem_req;
    logic       dmem_we;
  } out_t;

  typedef struct {
    logic [5:0]       op;
    logic             z;
    logic             ir;
    logic             dr;
    logic [2:0]       st;
    out_t             o;
    logic [CNT_W-1:0] ret;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] op, input int z, ir, dr, st,
                              input int ireq, irw, pcw, pcs, rw, ro, wd, m2r,
                              input int asb, ext, aop, dreq, dwe, ret);
    vec_t v;
    v.op = op; v.z = 1'(z); v.ir = 1'(ir); v.dr = 1'(dr); v.st = 3'(st);
    v.o.imem_req = 1'(ireq); v.o.ir_wre = 1'(irw); v.o.pc_wre = 1'(pcw);
    v.o.pc_src = 2'(pcs); v.o.reg_wre = 1'(rw); v.o.reg_out = 2'(ro);
    v.o.wr_reg_data = 1'(wd); v.o.alu_m2reg = 1'(m2r); v.o.alu_src_b = 1'(asb);
    v.o.ext_sel = 2'(ext); v.o.alu_op = 3'(aop); v.o.dmem_req = 1'(dreq);
    v.o.dmem_we = 1'(dwe); v.ret = CNT_W'(ret);
    return v;
  endfunction

  function automatic out_t cur_out();
    return {imem_req, ir_wre, pc_wre, pc_src, reg_wre, reg_out, wr_reg_data,
            alu_m2reg, alu_src_b, ext_sel, alu_op, dmem_req, dmem_we};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic ir, input logic dr);
    opcode = op; zero = z; imem_ready = ir; dmem_ready = dr;
  endtask

  // Holds reset for two cycles, checks reset outputs, releases on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(R, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("reset state", 32'(state), 32'd0);
    check("reset enables", 32'(cur_out()), 32'd0);
    check("reset retired", 32'(retired), 32'd0);
    check("reset flags", {30'd0, halted, fault}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    //     op   z ir dr st  ireq irw pcw pcs rw ro wd m2r asb ext aop dreq dwe ret
    tbl.push_back(mk(R,    0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R,    0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R,    1, 0, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R,    0, 1, 0, 4,  0, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(LW,   0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LW,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LW,   0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(LW,   0, 1, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LW,   0, 1, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LW,   0, 1, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LW,   0, 0, 1, 3,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LW,   0, 0, 0, 4,  0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(BEQ,  0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(BEQ,  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(BEQ,  1, 0, 0, 2,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(BEQ,  1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(BEQ,  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(BEQ,  0, 0, 1, 2,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(JAL,  0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(JAL,  0, 0, 0, 1,  0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(SW,   0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(SW,   0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(SW,   0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(SW,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(SW,   0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5));
    tbl.push_back(mk(SW,   0, 0, 1, 3,  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 5));
    tbl.push_back(mk(ADDI, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(ADDI, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(ADDI, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6));
    tbl.push_back(mk(ADDI, 0, 0, 0, 4,  0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(JR,   0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(JR,   0, 0, 0, 1,  0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(J,    0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    tbl.push_back(mk(J,    0, 0, 0, 1,  0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].z, tbl[i].ir, tbl[i].dr);
      #2;
      check($sformatf("row%0d state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("row%0d outputs", i), 32'(cur_out()), 32'(tbl[i].o));
      check($sformatf("row%0d retired", i), 32'(retired), 32'(tbl[i].ret));
      @(negedge clk);
    end

    // Back-to-back jumps carry the retired counter through its wrap to 0.
    for (int k = 0; k < 8; k++) begin
      drive(J, 1'b0, 1'b1, 1'b0);
      #2;
      check($sformatf("wrap retired %0d", k), 32'(retired), 32'((9 + k) % 16));
      @(negedge clk);
      #2;
      check($sformatf("wrap pc_wre %0d", k), {31'd0, pc_wre}, 32'd1);
      @(negedge clk);
    end

    // One jump, then halt: retired stays 1, HALT absorbs.
    do_reset();
    drive(J, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    drive(HALT, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    check("halt ID pc_wre", {31'd0, pc_wre}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #2;
      check("halt state", 32'(state), 32'd5);
      check("halt flags", {30'd0, halted, fault}, 32'd2);
      check("halt enables", 32'(cur_out()), 32'd0);
      check("halt retired", 32'(retired), 32'd1);
      @(negedge clk);
    end

    // Illegal opcode faults straight out of ID.
    do_reset();
    drive(ILL, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("illegal state", 32'(state), 32'd6);
      check("illegal flags", {30'd0, halted, fault}, 32'd1);
      check("illegal retired", 32'(retired), 32'd0);
      @(negedge clk);
    end

    // Fetch timeout: four unready cycles, fault on the fifth, sticky after ready.
    do_reset();
    drive(R, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      #2;
      check($sformatf("if timeout cycle %0d", k), 32'(state), (k < 5) ? 32'd0 : 32'd6);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    repeat (3) begin
      #2;
      check("fault sticky", {29'd0, state}, 32'd6);
      check("fault flag", {31'd0, fault}, 32'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset enables", 32'(cur_out()), 32'd0);
    @(negedge clk);

    // Data-memory timeout: lw held in MEM for four unready cycles.
    do_reset();
    drive(LW, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      #2;
      check($sformatf("mem timeout cycle %0d", k), 32'(state), (k < 5) ? 32'd3 : 32'd6);
      @(negedge clk);
    end

    // Reset in the middle of a store aborts it immediately.
    do_reset();
    drive(SW, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    check("mid sw dmem_we", {30'd0, dmem_req, dmem_we}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid abort state", 32'(state), 32'd0);
    check("mid abort enables", 32'(cur_out()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
